// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared state codes, opcodes and control encodings for mc_control_unit
package cu_pkg;

  // Five-bit state codes; the code is also shown on status[4:0].
  typedef enum logic [4:0] {
    ST_RESET   = 5'd0,
    ST_FETCH   = 5'd1,
    ST_DECODE  = 5'd2,
    ST_MOV     = 5'd3,
    ST_ADD     = 5'd4,
    ST_SUB     = 5'd5,
    ST_CMP     = 5'd6,
    ST_SHL     = 5'd7,
    ST_SHR     = 5'd8,
    ST_INC     = 5'd9,
    ST_DEC     = 5'd10,
    ST_LD      = 5'd11,
    ST_STO     = 5'd12,
    ST_LDI     = 5'd13,
    ST_JE      = 5'd14,
    ST_JNE     = 5'd15,
    ST_JC      = 5'd16,
    ST_JMP     = 5'd17,
    ST_HALT    = 5'd18,
    ST_CALL1   = 5'd19,
    ST_CALL2   = 5'd20,
    ST_RET1    = 5'd21,
    ST_EI      = 5'd22,
    ST_DI      = 5'd23,
    ST_INT1    = 5'd24,
    ST_INT2    = 5'd25,
    ST_ILLEGAL = 5'd31
  } state_t;

  localparam logic [6:0] OP_ADD  = 7'h70;
  localparam logic [6:0] OP_SUB  = 7'h71;
  localparam logic [6:0] OP_CMP  = 7'h72;
  localparam logic [6:0] OP_MOV  = 7'h73;
  localparam logic [6:0] OP_SHL  = 7'h74;
  localparam logic [6:0] OP_SHR  = 7'h75;
  localparam logic [6:0] OP_INC  = 7'h76;
  localparam logic [6:0] OP_DEC  = 7'h77;
  localparam logic [6:0] OP_LD   = 7'h78;
  localparam logic [6:0] OP_STO  = 7'h79;
  localparam logic [6:0] OP_LDI  = 7'h7A;
  localparam logic [6:0] OP_HALT = 7'h7B;
  localparam logic [6:0] OP_JE   = 7'h7C;
  localparam logic [6:0] OP_JNE  = 7'h7D;
  localparam logic [6:0] OP_JC   = 7'h7E;
  localparam logic [6:0] OP_JMP  = 7'h7F;
  localparam logic [6:0] OP_CALL = 7'h6C;
  localparam logic [6:0] OP_RET  = 7'h6D;
  localparam logic [6:0] OP_EI   = 7'h6E;
  localparam logic [6:0] OP_DI   = 7'h6F;

  localparam logic [3:0] ALU_PASS = 4'b0000;
  localparam logic [3:0] ALU_INC  = 4'b0010;
  localparam logic [3:0] ALU_DEC  = 4'b0011;
  localparam logic [3:0] ALU_ADD  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0101;
  localparam logic [3:0] ALU_SHR  = 4'b0110;
  localparam logic [3:0] ALU_SHL  = 4'b0111;

  localparam logic [1:0] ADR_PC  = 2'd0;
  localparam logic [1:0] ADR_REG = 2'd1;
  localparam logic [1:0] ADR_SP  = 2'd2;

  localparam logic [1:0] SSEL_ALU = 2'd0;
  localparam logic [1:0] SSEL_MEM = 2'd1;
  localparam logic [1:0] SSEL_PC  = 2'd2;

  localparam logic [1:0] PCSEL_REL = 2'd0;
  localparam logic [1:0] PCSEL_REG = 2'd1;
  localparam logic [1:0] PCSEL_MEM = 2'd2;
  localparam logic [1:0] PCSEL_VEC = 2'd3;

  // ALU function driven while sitting in an ALU state; CMP subtracts without writing back.
  function automatic logic [3:0] alu_op_of(state_t s);
    case (s)
      ST_ADD:          return ALU_ADD;
      ST_SUB, ST_CMP:  return ALU_SUB;
      ST_SHL:          return ALU_SHL;
      ST_SHR:          return ALU_SHR;
      ST_INC:          return ALU_INC;
      ST_DEC:          return ALU_DEC;
      default:         return ALU_PASS;
    endcase
  endfunction

endpackage

// File: rtl/cu_decode.sv
// rtl/cu_decode.sv - opcode to first execution state map
module cu_decode
  import cu_pkg::*;
(
  input  logic [6:0] opcode_i,
  output state_t     next_state_o
);

  // Anything not in the instruction set lands in ILLEGAL.
  always_comb begin
    next_state_o = ST_ILLEGAL;
    case (opcode_i)
      OP_ADD:  next_state_o = ST_ADD;
      OP_SUB:  next_state_o = ST_SUB;
      OP_CMP:  next_state_o = ST_CMP;
      OP_MOV:  next_state_o = ST_MOV;
      OP_SHL:  next_state_o = ST_SHL;
      OP_SHR:  next_state_o = ST_SHR;
      OP_INC:  next_state_o = ST_INC;
      OP_DEC:  next_state_o = ST_DEC;
      OP_LD:   next_state_o = ST_LD;
      OP_STO:  next_state_o = ST_STO;
      OP_LDI:  next_state_o = ST_LDI;
      OP_HALT: next_state_o = ST_HALT;
      OP_JE:   next_state_o = ST_JE;
      OP_JNE:  next_state_o = ST_JNE;
      OP_JC:   next_state_o = ST_JC;
      OP_JMP:  next_state_o = ST_JMP;
      OP_CALL: next_state_o = ST_CALL1;
      OP_RET:  next_state_o = ST_RET1;
      OP_EI:   next_state_o = ST_EI;
      OP_DI:   next_state_o = ST_DI;
      default: next_state_o = ST_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multi-cycle Moore control unit with wait states, CALL/RET and interrupt
module mc_control_unit
  import cu_pkg::*;
#(
  parameter int DW           = 16,
  parameter int RA           = 3,
  parameter bit ILLEGAL_STOP = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] IR,
  input  logic          N,
  input  logic          Z,
  input  logic          C,
  input  logic          mem_rdy,
  input  logic          irq,
  output logic [RA-1:0] W_Adr,
  output logic [RA-1:0] R_Adr,
  output logic [RA-1:0] S_Adr,
  output logic [1:0]    adr_sel,
  output logic [1:0]    s_sel,
  output logic          md_sel,
  output logic          pc_ld,
  output logic          pc_inc,
  output logic [1:0]    pc_sel,
  output logic          ir_ld,
  output logic          mw_en,
  output logic          rw_en,
  output logic          sp_inc,
  output logic          sp_dec,
  output logic [3:0]    alu_op,
  output logic          irq_ack,
  output logic          ie,
  output logic [7:0]    status
);

  state_t       state_q, state_d;
  state_t       dec_state;
  logic [2:0]   flags_q, flags_d;   // {N, Z, C}
  logic         ie_q, ie_d;
  logic [RA-1:0] w_fld, r_fld, s_fld;
  logic         take_irq;

  assign w_fld    = IR[3*RA-1:2*RA];
  assign r_fld    = IR[2*RA-1:RA];
  assign s_fld    = IR[RA-1:0];
  assign take_irq = irq & ie_q;

  cu_decode u_decode (
    .opcode_i     (IR[DW-1:DW-7]),
    .next_state_o (dec_state)
  );

  // State, flag and interrupt-enable registers; reset aborts any access in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RESET;
      flags_q <= 3'b000;
      ie_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      ie_q    <= ie_d;
    end
  end

  // Next-state and control word; every output starts from the idle control word.
  always_comb begin
    state_d = state_q;
    flags_d = flags_q;
    ie_d    = ie_q;
    W_Adr   = '0;
    R_Adr   = '0;
    S_Adr   = '0;
    adr_sel = ADR_PC;
    s_sel   = SSEL_ALU;
    md_sel  = 1'b0;
    pc_ld   = 1'b0;
    pc_inc  = 1'b0;
    pc_sel  = PCSEL_REL;
    ir_ld   = 1'b0;
    mw_en   = 1'b0;
    rw_en   = 1'b0;
    sp_inc  = 1'b0;
    sp_dec  = 1'b0;
    alu_op  = ALU_PASS;
    irq_ack = 1'b0;
    case (state_q)
      ST_RESET: state_d = ST_FETCH;
      ST_FETCH: begin
        // The interrupt wins even if the fetch would complete this cycle,
        // so the PC is never advanced past an instruction that is not run.
        if (take_irq) begin
          state_d = ST_INT1;
        end else begin
          adr_sel = ADR_PC;
          if (mem_rdy) begin
            ir_ld   = 1'b1;
            pc_inc  = 1'b1;
            state_d = ST_DECODE;
          end
        end
      end
      ST_DECODE: state_d = dec_state;
      ST_MOV, ST_ADD, ST_SUB, ST_CMP, ST_SHL, ST_SHR, ST_INC, ST_DEC: begin
        W_Adr   = w_fld;
        R_Adr   = r_fld;
        S_Adr   = s_fld;
        rw_en   = (state_q != ST_CMP);
        alu_op  = alu_op_of(state_q);
        if (state_q != ST_MOV) flags_d = {N, Z, C};
        state_d = ST_FETCH;
      end
      ST_LD: begin
        adr_sel = ADR_REG;
        R_Adr   = s_fld;
        W_Adr   = w_fld;
        s_sel   = SSEL_MEM;
        if (mem_rdy) begin
          rw_en   = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_STO: begin
        adr_sel = ADR_REG;
        R_Adr   = w_fld;
        S_Adr   = s_fld;
        mw_en   = 1'b1;
        if (mem_rdy) state_d = ST_FETCH;
      end
      ST_LDI: begin
        adr_sel = ADR_PC;
        W_Adr   = w_fld;
        s_sel   = SSEL_MEM;
        if (mem_rdy) begin
          rw_en   = 1'b1;
          pc_inc  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_JE: begin
        pc_ld   = flags_q[1];
        state_d = ST_FETCH;
      end
      ST_JNE: begin
        pc_ld   = ~flags_q[1];
        state_d = ST_FETCH;
      end
      ST_JC: begin
        pc_ld   = flags_q[0];
        state_d = ST_FETCH;
      end
      ST_JMP: begin
        S_Adr   = s_fld;
        pc_sel  = PCSEL_REG;
        pc_ld   = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        // PC already points past HALT, so the pushed return address resumes after it.
        if (take_irq) state_d = ST_INT1;
      end
      ST_CALL1: begin
        sp_dec  = 1'b1;
        state_d = ST_CALL2;
      end
      ST_CALL2, ST_INT2: begin
        adr_sel = ADR_SP;
        md_sel  = 1'b1;
        mw_en   = 1'b1;
        if (state_q == ST_CALL2) begin
          S_Adr  = s_fld;
          pc_sel = PCSEL_REG;
        end else begin
          pc_sel = PCSEL_VEC;
        end
        if (mem_rdy) begin
          pc_ld   = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_RET1: begin
        adr_sel = ADR_SP;
        pc_sel  = PCSEL_MEM;
        if (mem_rdy) begin
          pc_ld   = 1'b1;
          sp_inc  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_EI: begin
        ie_d    = 1'b1;
        state_d = ST_FETCH;
      end
      ST_DI: begin
        ie_d    = 1'b0;
        state_d = ST_FETCH;
      end
      ST_INT1: begin
        sp_dec  = 1'b1;
        irq_ack = 1'b1;
        ie_d    = 1'b0;
        state_d = ST_INT2;
      end
      ST_ILLEGAL: state_d = ILLEGAL_STOP ? ST_ILLEGAL : ST_FETCH;
      default:    state_d = ST_RESET;
    endcase
  end

  // Debug view: flags plus state code, with fixed patterns for RESET and ILLEGAL.
  always_comb begin
    ie = ie_q;
    if (state_q == ST_RESET)        status = 8'hFF;
    else if (state_q == ST_ILLEGAL) status = 8'hF0;
    else                            status = {flags_q, state_q};
  end

endmodule
